// File: rtl/led_blink_driver.sv
// Purpose : turn single-cycle event strobes into visible LED blinks of fixed on/off time,
//           queueing strobes that arrive mid-blink in a saturating counter.
// Latency : LED lights on the cycle after the accepted strobe; all outputs registered.
// Backpressure: none; strobes beyond MAX_PENDING queued requests are dropped and flagged sticky.
//
// Ports:
//   clock          system clock, posedge
//   reset          synchronous active-high reset
//   trigger        blink request strobe, one request per high cycle
//   clear_overflow synchronous clear of the overflow flag
//   led_out        LED drive, lit level set by ACTIVE_LOW
//   busy           high while a blink (on or off phase) is in progress
//   pending_count  queued requests, excluding the blink in progress
//   overflow       sticky: a request was dropped because the queue was full
module led_blink_driver #(
  parameter int ON_CYCLES   = 1000,
  parameter int OFF_CYCLES  = 1000,
  parameter int MAX_PENDING = 15,
  parameter bit ACTIVE_LOW  = 1'b1,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          trigger,
  input  logic          clear_overflow,
  output logic          led_out,
  output logic          busy,
  output logic [PW-1:0] pending_count,
  output logic          overflow
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  localparam logic          LED_DARK = ACTIVE_LOW;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          led_q, busy_q;
  logic          trig_enq;
  logic          ovf_set;

  // A strobe is queued whenever a blink is running, except on the last
  // OFF cycle where it is consumed directly by the next blink start.
  assign trig_enq = trigger &&
                    ((state_q == S_ON) || ((state_q == S_OFF) && (timer_q != '0)));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_ON;
          timer_d = ON_LOAD;
        end
      end
      S_ON: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = S_OFF;
          timer_d = OFF_LOAD;
        end
      end
      S_OFF: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (pend_q != '0) begin
          // Dequeue; a simultaneous strobe replaces the dequeued entry.
          state_d = S_ON;
          timer_d = ON_LOAD;
          if (!trigger) pend_d = pend_q - 1'b1;
        end else if (trigger) begin
          state_d = S_ON;
          timer_d = ON_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (trig_enq) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_d  = pend_q + 1'b1;
    end

    // Setting wins over clearing.
    ovf_d = ovf_set | (ovf_q & ~clear_overflow);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= LED_DARK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      // Outputs are registered from the next state so they align with it.
      led_q   <= (state_d == S_ON) ? ~LED_DARK : LED_DARK;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign led_out       = led_q;
  assign busy          = busy_q;
  assign pending_count = pend_q;
  assign overflow      = ovf_q;

endmodule
